// File: rtl/student_coeff_reader_pkg.sv
// Shared types and constants for the coefficient BRAM read sequencer.
// Holds the FSM state type, the default buffer entry layout and the buffer depth.
package student_coeff_reader_pkg;

    localparam int unsigned DefAddrWidth     = 10;
    localparam int unsigned DefCoeffDataSize = 16;
    localparam int unsigned BufDepth         = 2;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain
    } state_e;

    // Default-sized entry layout; the top packs entries in this same field order.
    typedef struct packed {
        logic [DefCoeffDataSize-1:0] coeff;
        logic [DefAddrWidth-1:0]     idx;
        logic                        last;
    } buf_entry_t;

endpackage

// File: rtl/student_coeff_skid_fifo.sv
// Two-entry valid/ready FIFO whose head is the output.
// Exposes its occupancy so the producer can run a credit check.
module student_coeff_skid_fifo
    import student_coeff_reader_pkg::*;
#(
    parameter int unsigned Width = 27
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [Width-1:0] head_o,
    output logic [1:0]       count_o
);

    localparam logic [1:0] Full = 2'(BufDepth);

    logic [Width-1:0] r_mem0;
    logic [Width-1:0] r_mem1;
    logic [1:0]       r_count;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = pop_i && (r_count != 2'd0);
    assign w_push = push_i && ((r_count != Full) || w_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mem0  <= '0;
            r_mem1  <= '0;
            r_count <= 2'd0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_mem0 <= push_data_i;
                    end else begin
                        r_mem1 <= push_data_i;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_mem0  <= r_mem1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; only the slot the new word lands in differs.
                    if (r_count == 2'd1) begin
                        r_mem0 <= push_data_i;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= push_data_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign valid_o = (r_count != 2'd0);
    assign head_o  = r_mem0;
    assign count_o = r_count;

endmodule

// File: rtl/student_coeff_reader.sv
// Read-side sequencer for the coefficient BRAM: fetches a programmable run of words
// and streams them out as valid/ready beats tagged with index and last.
module student_coeff_reader
    import student_coeff_reader_pkg::*;
#(
    parameter int unsigned AddrWidth     = DefAddrWidth,
    parameter int unsigned CoeffDataSize = DefCoeffDataSize
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [AddrWidth-1:0]     base_addr_i,
    input  logic [AddrWidth:0]       num_taps_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     enb_o,
    output logic [AddrWidth-1:0]     addrb_o,
    input  logic [CoeffDataSize-1:0] dob_i,
    output logic [CoeffDataSize-1:0] coeff_o,
    output logic                     coeff_valid_o,
    input  logic                     coeff_ready_i,
    output logic                     coeff_last_o,
    output logic [AddrWidth-1:0]     coeff_idx_o
);

    localparam int unsigned EntryWidth = CoeffDataSize + AddrWidth + 1;

    state_e                r_state;
    state_e                w_state_next;
    logic [AddrWidth-1:0]  r_base;
    logic [AddrWidth:0]    r_num;
    logic [AddrWidth:0]    r_issued;
    logic                  r_inflight;
    logic [AddrWidth-1:0]  r_rd_idx;
    logic                  r_rd_last;
    logic                  r_done;

    logic                  w_fifo_valid;
    logic [EntryWidth-1:0] w_head;
    logic [1:0]            w_occ;
    logic                  w_hs;
    logic                  w_last_hs;
    logic [2:0]            w_pending;
    logic                  w_issue;
    logic                  w_issue_last;
    logic                  w_start_run;
    logic                  w_start_empty;

    assign w_hs          = w_fifo_valid && coeff_ready_i;
    assign w_last_hs     = w_hs && w_head[0];
    assign w_start_run   = (r_state == StIdle) && start_i && (num_taps_i != '0);
    assign w_start_empty = (r_state == StIdle) && start_i && (num_taps_i == '0);

    // The beat leaving this cycle frees its slot, which keeps the stream bubble-free.
    assign w_pending    = 3'(w_occ) + 3'(r_inflight) - 3'(w_hs);
    assign w_issue      = (r_state == StFetch) && (r_issued < r_num)
                          && (w_pending < 3'(BufDepth));
    assign w_issue_last = w_issue && (r_issued == r_num - 1'b1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_start_run)  w_state_next = StFetch;
            StFetch: if (w_issue_last) w_state_next = StDrain;
            StDrain: if (w_last_hs)    w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        busy_o  = (r_state != StIdle);
        enb_o   = w_issue;
        addrb_o = r_base + r_issued[AddrWidth-1:0];
        done_o  = r_done;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_base     <= '0;
            r_num      <= '0;
            r_issued   <= '0;
            r_inflight <= 1'b0;
            r_rd_idx   <= '0;
            r_rd_last  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_start_run) begin
                r_base   <= base_addr_i;
                r_num    <= num_taps_i;
                r_issued <= '0;
            end else if (w_issue) begin
                r_issued <= r_issued + 1'b1;
            end
            // Tags travel with the read so the returning word lands with its index.
            r_inflight <= w_issue;
            r_rd_idx   <= r_issued[AddrWidth-1:0];
            r_rd_last  <= w_issue_last;
            r_done     <= w_start_empty || ((r_state == StDrain) && w_last_hs);
        end
    end

    student_coeff_skid_fifo #(
        .Width(EntryWidth)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (r_inflight),
        .push_data_i ({dob_i, r_rd_idx, r_rd_last}),
        .pop_i       (coeff_ready_i),
        .valid_o     (w_fifo_valid),
        .head_o      (w_head),
        .count_o     (w_occ)
    );

    assign coeff_valid_o = w_fifo_valid;
    assign coeff_o       = w_head[EntryWidth-1 -: CoeffDataSize];
    assign coeff_idx_o   = w_head[AddrWidth:1];
    assign coeff_last_o  = w_head[0] && w_fifo_valid;

endmodule
